// File: rtl/pio_dac_spi_tx.sv
// ---------------------------------------------------------------------------
// pio_dac_spi_tx
//
// Serializes the 8-bit Avalon PIO output word to an external SPI DAC whenever
// that word changes. Software updates the DAC with a plain PIO write. This
// block has no bus slave of its own.
//
// Frame format: {CMD, pio word, zero pad up to 12 bits}, 16 bits, MSB first.
// SPI mode 0: SCLK idles low, DIN changes only while SCLK is low, and the DAC
// samples DIN on the rising edge of SCLK.
//
// Parameters
//   DATA_W   width of pio_data (1..12)
//   CLK_DIV  clk cycles per SCLK half-period (>= 1)
//   CS_GAP   clk cycles dac_cs_n stays high after a frame (>= 1)
//   CMD      4-bit DAC command nibble placed in frame[15:12]
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous, active-low reset
//   pio_data    in   parallel word from the PIO out_port
//   enable      in   1 = new frames may start; 0 = no new frame starts
//   dac_cs_n    out  DAC chip select, active low
//   dac_sclk    out  DAC serial clock
//   dac_din     out  DAC serial data
//   busy        out  high from LOAD through the end of HOLD
//   frame_done  out  one-cycle pulse in the cycle dac_cs_n returns high
// ---------------------------------------------------------------------------
module pio_dac_spi_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter logic [3:0]  CMD     = 4'h3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pio_data,
  input  logic              enable,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              busy,
  output logic              frame_done
);

  // The divider counter only has to reach CLK_DIV-1. It is sized to hold
  // CLK_DIV so that CLK_DIV=1 still gets a one-bit counter.
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [4:0]       BIT_LAST = 5'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] pio_q;
  logic [DATA_W-1:0] snapshot_q;
  logic              sentValid_q;
  logic [14:0]       shReg_q;
  logic [4:0]        bitCnt_q;
  logic [DIV_W-1:0]  divCnt_q;
  logic [GAP_W-1:0]  gapCnt_q;
  logic              csN_q;
  logic              sclk_q;
  logic              din_q;
  logic              busy_q;
  logic              frameDone_q;

  logic [11:0]       payload_d;
  logic [15:0]       frame_d;
  logic              changed_d;

  // Frame assembly and change detection both work from the registered copy
  // of the PIO word. The payload is left-justified in its 12-bit field, so
  // narrower words get zero padding at the LSB end. The first frame after
  // reset is always sent, because there is no valid snapshot to compare with.
  always_comb begin
    payload_d = 12'(pio_q) << (12 - DATA_W);
    frame_d   = {CMD, payload_d};
    changed_d = !sentValid_q || (pio_q != snapshot_q);
  end

  // Single FSM with registered outputs.
  // In SHIFT, each bit is CLK_DIV cycles with SCLK low followed by CLK_DIV
  // cycles with SCLK high. The next bit goes onto DIN in the same edge that
  // drops SCLK, so DIN is stable for the whole high phase. The MSB is placed
  // on DIN during LOAD, so the shift register only holds bits 14..0.
  // PIO changes that arrive while a frame is in flight are only seen again
  // in IDLE. At that point only the latest value is sent, and intermediate
  // values are lost on purpose.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pio_q       <= '0;
      snapshot_q  <= '0;
      sentValid_q <= 1'b0;
      shReg_q     <= '0;
      bitCnt_q    <= '0;
      divCnt_q    <= '0;
      gapCnt_q    <= '0;
      csN_q       <= 1'b1;
      sclk_q      <= 1'b0;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      pio_q       <= pio_data;
      frameDone_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (enable && changed_d) begin
            state_q <= LOAD;
          end
        end

        LOAD: begin
          snapshot_q  <= pio_q;
          sentValid_q <= 1'b1;
          shReg_q     <= frame_d[14:0];
          din_q       <= frame_d[15];
          csN_q       <= 1'b0;
          sclk_q      <= 1'b0;
          busy_q      <= 1'b1;
          bitCnt_q    <= '0;
          divCnt_q    <= '0;
          state_q     <= SHIFT;
        end

        SHIFT: begin
          if (divCnt_q == DIV_LAST) begin
            divCnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bitCnt_q == BIT_LAST) begin
              // The 16th high phase has ended. Close the frame.
              bitCnt_q    <= bitCnt_q + 5'd1;
              sclk_q      <= 1'b0;
              csN_q       <= 1'b1;
              din_q       <= 1'b0;
              frameDone_q <= 1'b1;
              gapCnt_q    <= '0;
              state_q     <= HOLD;
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
              sclk_q   <= 1'b0;
              din_q    <= shReg_q[14];
              shReg_q  <= {shReg_q[13:0], 1'b0};
            end
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
        end

        HOLD: begin
          if (gapCnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q + GAP_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dac_cs_n   = csN_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_pio_dac_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_pio_dac_spi_tx
//
// Self-checking bench for pio_dac_spi_tx with CLK_DIV=2, CS_GAP=2, CMD=3 and
// DATA_W=8. Stimulus pushes each expected frame word into a queue. A SPI
// monitor rebuilds every frame from the pins, then pops the queue and
// compares against the popped word. Single-write cases are listed in a
// vector table. The multi-cycle corner cases use hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pio_dac_spi_tx;

  localparam int CLK_DIV  = 2;
  localparam int CS_GAP   = 2;
  localparam int LOW_CYC  = 32 * CLK_DIV;
  localparam int BUDGET   = 2000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pio_data;
  logic       enable;
  logic       dac_cs_n;
  logic       dac_sclk;
  logic       dac_din;
  logic       busy;
  logic       frame_done;

  typedef struct {
    logic [7:0]  pioVal;
    logic        en;
    logic        expectFrame;
    logic [15:0] frameVal;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  logic [15:0] expQ [$];

  int checksTotal  = 0;
  int checksPassed = 0;

  // Monitor state
  int          framesSeen  = 0;
  int          pulseCount  = 0;
  int          riseCount   = 0;
  int          lowCycles   = 0;
  logic        inFrame     = 1'b0;
  logic        busySeen    = 1'b0;
  logic        dinUnstable = 1'b0;
  logic        heldDin     = 1'b0;
  logic        prevCs      = 1'b1;
  logic        prevSclk    = 1'b0;
  logic [15:0] shiftIn     = '0;

  pio_dac_spi_tx #(
    .DATA_W (8),
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP),
    .CMD    (4'h3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pio_data  (pio_data),
    .enable    (enable),
    .dac_cs_n  (dac_cs_n),
    .dac_sclk  (dac_sclk),
    .dac_din   (dac_din),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Last-resort watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // The monitor samples on the falling clock edge, away from DUT updates.
  // It rebuilds the frame from DIN at each SCLK rise and checks the frame
  // shape when chip select goes high again.
  always @(negedge clk) begin
    if (!reset_n) begin
      inFrame  = 1'b0;
      prevCs   = 1'b1;
      prevSclk = 1'b0;
    end else begin
      if (frame_done) pulseCount++;
      if (busy) busySeen = 1'b1;
      if (prevCs && !dac_cs_n) begin
        inFrame     = 1'b1;
        shiftIn     = '0;
        riseCount   = 0;
        lowCycles   = 0;
        dinUnstable = 1'b0;
      end
      if (inFrame && !dac_cs_n) begin
        lowCycles++;
        if (!prevSclk && dac_sclk) begin
          shiftIn = {shiftIn[14:0], dac_din};
          heldDin = dac_din;
          riseCount++;
        end else if (prevSclk && dac_sclk && (dac_din !== heldDin)) begin
          dinUnstable = 1'b1;
        end
      end
      if (inFrame && !prevCs && dac_cs_n) begin
        inFrame = 1'b0;
        framesSeen++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_frame", {16'h0, shiftIn}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("frame_word", {16'h0, shiftIn}, {16'h0, expQ.pop_front()});
        end
        checkOutput("sclk_rises", riseCount, 16);
        checkOutput("cs_low_cycles", lowCycles, LOW_CYC);
        checkOutput("frame_done_at_cs_rise", {31'h0, frame_done}, 32'h1);
        checkOutput("din_stable_sclk_high", {31'h0, dinUnstable}, 32'h0);
      end
      prevCs   = dac_cs_n;
      prevSclk = dac_sclk;
    end
  end

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    pio_data = v.pioVal;
    enable   = v.en;
    if (v.expectFrame) expQ.push_back(v.frameVal);
  endtask

  task automatic waitFrames(input int target);
    int n = 0;
    while (framesSeen < target && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    checkOutput("frames_reached", framesSeen, target);
  endtask

  task automatic waitCsLow();
    int n = 0;
    while (dac_cs_n !== 1'b0 && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    checkOutput("cs_went_low", {31'h0, dac_cs_n}, 32'h0);
  endtask

  task automatic settle();
    int n = 0;
    while (busy !== 1'b0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_dropped", {31'h0, busy}, 32'h0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int   base;
    int   n;
    logic [7:0] rv;

    vecs[0] = '{8'h5A, 1'b1, 1'b1, 16'h35A0};
    vecs[1] = '{8'h5A, 1'b1, 1'b0, 16'h0000};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 16'h3FF0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 16'h3010};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{8'h7E, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 16'h37E0};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 16'h3800};

    // Reset state
    reset_n  = 1'b0;
    pio_data = 8'h00;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", {31'h0, dac_cs_n}, 32'h1);
    checkOutput("reset_sclk", {31'h0, dac_sclk}, 32'h0);
    checkOutput("reset_din", {31'h0, dac_din}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_frame_done", {31'h0, frame_done}, 32'h0);

    // First frame after reset is sent even for value 0, then stays idle
    expQ.push_back(16'h3000);
    #2 reset_n = 1'b1;
    waitFrames(1);
    settle();
    busySeen = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("idle_after_first_frames", framesSeen, 1);
    checkOutput("idle_after_first_busy", {31'h0, busySeen}, 32'h0);

    // Latency: change just after edge P, cs_n still high after P+2, low after P+3
    $display("[TB] latency sequence");
    base = framesSeen;
    @(posedge clk);
    #1 pio_data = 8'hA5;
    expQ.push_back(16'h3A50);
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("latency_cs_high_edge2", {31'h0, dac_cs_n}, 32'h1);
    @(posedge clk);
    #1 checkOutput("latency_cs_low_edge3", {31'h0, dac_cs_n}, 32'h0);
    checkOutput("latency_busy_high", {31'h0, busy}, 32'h1);
    waitFrames(base + 1);
    settle();

    // Table-driven single writes
    $display("[TB] vector table");
    for (int i = 0; i < NV; i++) begin
      base     = framesSeen;
      busySeen = 1'b0;
      applyStimulus(vecs[i]);
      if (vecs[i].expectFrame) begin
        waitFrames(base + 1);
        settle();
      end else begin
        repeat (100) @(negedge clk);
        checkOutput($sformatf("no_frame_busy_v%0d", i), {31'h0, busySeen}, 32'h0);
        checkOutput($sformatf("no_frame_count_v%0d", i), framesSeen, base);
      end
    end

    // Random values
    for (int i = 0; i < 3; i++) begin
      base = framesSeen;
      rv   = 8'($urandom_range(0, 255));
      n    = 0;
      while (rv == pio_data && n < 16) begin
        rv = 8'($urandom_range(0, 255));
        n++;
      end
      if (rv == pio_data) rv = ~pio_data;
      applyStimulus('{rv, 1'b1, 1'b1, {4'h3, rv, 4'h0}});
      waitFrames(base + 1);
      settle();
    end

    // Changes during a frame: only the latest value follows
    $display("[TB] drop sequence");
    base = framesSeen;
    applyStimulus('{8'h11, 1'b1, 1'b1, 16'h3110});
    waitCsLow();
    repeat (10) @(negedge clk);
    pio_data = 8'h22;
    repeat (20) @(negedge clk);
    pio_data = 8'h33;
    expQ.push_back(16'h3330);
    waitFrames(base + 2);
    settle();
    repeat (200) @(negedge clk);
    checkOutput("drop_frame_count", framesSeen, base + 2);

    // enable low mid-frame: frame completes, nothing new until enable returns
    $display("[TB] enable sequence");
    base = framesSeen;
    applyStimulus('{8'h44, 1'b1, 1'b1, 16'h3440});
    waitCsLow();
    @(negedge clk);
    enable   = 1'b0;
    pio_data = 8'h55;
    waitFrames(base + 1);
    repeat (200) @(negedge clk);
    checkOutput("enable_off_frames", framesSeen, base + 1);
    checkOutput("enable_off_busy", {31'h0, busy}, 32'h0);
    enable = 1'b1;
    expQ.push_back(16'h3550);
    waitFrames(base + 2);
    settle();

    // Reset mid-frame: async return to reset values, then a resend
    $display("[TB] reset sequence");
    base = framesSeen;
    @(negedge clk);
    pio_data = 8'h9C;
    n = 0;
    while (!(inFrame && riseCount >= 7) && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reached_bit7", {31'h0, (inFrame && riseCount >= 7)}, 32'h1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_cs_n", {31'h0, dac_cs_n}, 32'h1);
    checkOutput("abort_sclk", {31'h0, dac_sclk}, 32'h0);
    checkOutput("abort_din", {31'h0, dac_din}, 32'h0);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    expQ.push_back(16'h39C0);
    #2 reset_n = 1'b1;
    waitFrames(base + 1);
    settle();

    // Final bookkeeping
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("frame_done_pulses", pulseCount, framesSeen);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
